// File: rtl/instr_decode_stage_pkg.sv
// Shared datatypes for the decode stage: instruction formats, opcode constants
// and the entry record held in the main and skid slots.
package instr_decode_stage_pkg;

   typedef enum logic [2:0] {
      INSTR_R = 3'd0,
      INSTR_I = 3'd1,
      INSTR_S = 3'd2,
      INSTR_B = 3'd3,
      INSTR_U = 3'd4,
      INSTR_J = 3'd5
   } instr_type_e;

   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef struct packed {
      logic [31:0] ir;
      logic [31:0] pc;
      instr_type_e instr_type;
      logic        illegal;
   } decode_entry_t;

endpackage

// File: rtl/instr_decode_stage_opcode_decode.sv
// Combinational opcode classifier; unknown opcodes fall back to the I format
// and are flagged illegal.
module opcode_decode
   import instr_decode_stage_pkg::*;
(
   input  logic [6:0]  opcode,
   output instr_type_e instr_type,
   output logic        illegal
);

   always_comb begin
      instr_type = INSTR_I;
      illegal    = 1'b0;
      case (opcode)
         OP_OP:                                             instr_type = INSTR_R;
         OP_IMM, OP_LOAD, OP_JALR, OP_FENCE, OP_SYSTEM:     instr_type = INSTR_I;
         OP_STORE:                                          instr_type = INSTR_S;
         OP_BRANCH:                                         instr_type = INSTR_B;
         OP_LUI, OP_AUIPC:                                  instr_type = INSTR_U;
         OP_JAL:                                            instr_type = INSTR_J;
         default:                                           illegal    = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_decode_stage.sv
// Decode stage: registered two-entry (main + skid) buffer between fetch and
// the immediate generator, decoding each word as it is captured.
module instr_decode_stage
   import instr_decode_stage_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_ir,
   input  logic [31:0]      in_pc,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_ir,
   output logic [31:0]      out_pc,
   output logic [2:0]       out_instr_type,
   output logic             out_illegal,
   output logic [CNT_W-1:0] decoded_cnt
);

   decode_entry_t    main_q, main_d, skid_q, skid_d, new_entry;
   logic             main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   instr_type_e      dec_type;
   logic             dec_illegal;
   logic             accept, out_fire;

   opcode_decode u_opcode_decode (
      .opcode     (in_ir[6:0]),
      .instr_type (dec_type),
      .illegal    (dec_illegal)
   );

   assign in_ready = !skid_valid_q;
   assign accept   = in_valid && in_ready && !flush;
   assign out_fire = main_valid_q && out_ready;

   // Words with ir[1:0] != 2'b11 are compressed/invalid encodings here.
   always_comb begin
      new_entry.ir         = in_ir;
      new_entry.pc         = in_pc;
      new_entry.instr_type = (in_ir[1:0] == 2'b11) ? dec_type : INSTR_I;
      new_entry.illegal    = (in_ir[1:0] == 2'b11) ? dec_illegal : 1'b1;
   end

   // Main refills from skid first when it drains; otherwise new words go to
   // main if it is free, or park in skid behind a stalled main.
   always_comb begin
      main_d       = main_q;
      skid_d       = skid_q;
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      cnt_d        = cnt_q + CNT_W'(out_fire);
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!main_valid_q || out_ready) begin
         if (skid_valid_q) begin
            main_d       = skid_q;
            main_valid_d = 1'b1;
            skid_valid_d = accept;
            if (accept) skid_d = new_entry;
         end else begin
            main_valid_d = accept;
            if (accept) main_d = new_entry;
         end
      end else if (accept) begin
         skid_d       = new_entry;
         skid_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_q       <= '0;
         skid_q       <= '0;
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         cnt_q        <= '0;
      end else begin
         main_q       <= main_d;
         skid_q       <= skid_d;
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         cnt_q        <= cnt_d;
      end
   end

   assign out_valid      = main_valid_q;
   assign out_ir         = main_q.ir;
   assign out_pc         = main_q.pc;
   assign out_instr_type = main_q.instr_type;
   assign out_illegal    = main_q.illegal;
   assign decoded_cnt    = cnt_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage; a second instance with a 4-bit
// counter shares the stimulus to exercise counter wrap.
module tb_instr_decode_stage;

   logic        clk = 1'b0;
   logic        rst, in_valid, flush, out_ready;
   logic [31:0] in_ir, in_pc;
   logic        in_ready, out_valid, out_illegal;
   logic [31:0] out_ir, out_pc, decoded_cnt;
   logic [2:0]  out_instr_type;
   logic        in_ready_4, out_valid_4, out_illegal_4;
   logic [31:0] out_ir_4, out_pc_4;
   logic [2:0]  out_instr_type_4;
   logic [3:0]  decoded_cnt_4;

   int vectors     = 0;
   int miscompares = 0;
   int exp_cnt     = 0;

   localparam logic [2:0] T_R = 3'd0, T_I = 3'd1, T_S = 3'd2, T_B = 3'd3, T_U = 3'd4, T_J = 3'd5;

   always #5 clk = ~clk;

   instr_decode_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_ir(in_ir), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_ir(out_ir), .out_pc(out_pc),
      .out_instr_type(out_instr_type), .out_illegal(out_illegal),
      .decoded_cnt(decoded_cnt)
   );

   instr_decode_stage #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_4),
      .in_ir(in_ir), .in_pc(in_pc), .flush(flush), .out_valid(out_valid_4),
      .out_ready(out_ready), .out_ir(out_ir_4), .out_pc(out_pc_4),
      .out_instr_type(out_instr_type_4), .out_illegal(out_illegal_4),
      .decoded_cnt(decoded_cnt_4)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [31:0] ir, input logic [31:0] pc,
                                input logic ordy, input logic fl);
      in_valid  = v;
      in_ir     = ir;
      in_pc     = pc;
      out_ready = ordy;
      flush     = fl;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] words [8] = '{32'hFFFFFFFF, 32'h00000000, 32'h00112023, 32'h000000B7,
                              32'h00000033, 32'h00000017, 32'h0000007F, 32'h00000073};
   logic [2:0]  wtype [8] = '{T_I, T_I, T_S, T_U, T_R, T_U, T_I, T_I};
   logic        willeg [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

   initial begin
      rst = 1'b1;
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      tick();
      tick();
      rst = 1'b0;
      checkOutput("reset out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset in_ready", 32'(in_ready), 32'd1);
      checkOutput("reset cnt", decoded_cnt, 32'd0);
      checkOutput("reset out_ir", out_ir, 32'd0);
      checkOutput("reset out_pc", out_pc, 32'd0);
      checkOutput("reset type", 32'(out_instr_type), 32'd0);
      checkOutput("reset illegal", 32'(out_illegal), 32'd0);

      // addi, one cycle latency then consumed
      applyStimulus(1'b1, 32'h00500093, 32'h100, 1'b1, 1'b0);
      tick();
      checkOutput("addi valid", 32'(out_valid), 32'd1);
      checkOutput("addi ir", out_ir, 32'h00500093);
      checkOutput("addi pc", out_pc, 32'h100);
      checkOutput("addi type", 32'(out_instr_type), 32'(T_I));
      checkOutput("addi illegal", 32'(out_illegal), 32'd0);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      tick();
      exp_cnt = 1;
      checkOutput("addi cnt", decoded_cnt, 32'(exp_cnt));
      checkOutput("addi drained", 32'(out_valid), 32'd0);

      // B then J into a stalled stage
      applyStimulus(1'b1, 32'h00000463, 32'h200, 1'b0, 1'b0);
      tick();
      checkOutput("B in_ready", 32'(in_ready), 32'd1);
      applyStimulus(1'b1, 32'h0000006F, 32'h204, 1'b0, 1'b0);
      tick();
      checkOutput("full in_ready", 32'(in_ready), 32'd0);
      checkOutput("B ir", out_ir, 32'h00000463);
      checkOutput("B type", 32'(out_instr_type), 32'(T_B));
      applyStimulus(1'b1, 32'h00000013, 32'h208, 1'b0, 1'b0);
      tick();
      checkOutput("stall ir", out_ir, 32'h00000463);
      checkOutput("stall pc", out_pc, 32'h200);
      checkOutput("stall in_ready", 32'(in_ready), 32'd0);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      tick();
      exp_cnt++;
      checkOutput("J ir", out_ir, 32'h0000006F);
      checkOutput("J pc", out_pc, 32'h204);
      checkOutput("J type", 32'(out_instr_type), 32'(T_J));
      checkOutput("J in_ready", 32'(in_ready), 32'd1);
      checkOutput("B counted", decoded_cnt, 32'(exp_cnt));
      tick();
      exp_cnt++;
      checkOutput("J drained", 32'(out_valid), 32'd0);
      checkOutput("J counted", decoded_cnt, 32'(exp_cnt));

      // streaming decode table, including illegal words
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, words[i], 32'h300 + 32'(i * 4), 1'b1, 1'b0);
         tick();
         checkOutput($sformatf("tbl%0d ir", i), out_ir, words[i]);
         checkOutput($sformatf("tbl%0d type", i), 32'(out_instr_type), 32'(wtype[i]));
         checkOutput($sformatf("tbl%0d illegal", i), 32'(out_illegal), 32'(willeg[i]));
      end
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      tick();
      exp_cnt += 8;
      checkOutput("tbl cnt", decoded_cnt, 32'(exp_cnt));
      checkOutput("tbl drained", 32'(out_valid), 32'd0);

      // flush with both entries full
      applyStimulus(1'b1, 32'h00000013, 32'h400, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 32'h00000033, 32'h404, 1'b0, 1'b0);
      tick();
      checkOutput("preflush in_ready", 32'(in_ready), 32'd0);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      tick();
      checkOutput("flush out_valid", 32'(out_valid), 32'd0);
      checkOutput("flush in_ready", 32'(in_ready), 32'd1);
      checkOutput("flush cnt", decoded_cnt, 32'(exp_cnt));

      // flush ignores a same-cycle input handshake
      applyStimulus(1'b1, 32'h00000013, 32'h500, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 32'h00000033, 32'h504, 1'b0, 1'b1);
      tick();
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      tick();
      checkOutput("flush drop valid", 32'(out_valid), 32'd0);
      checkOutput("flush drop cnt", decoded_cnt, 32'(exp_cnt));

      // flush coinciding with output handshake still counts
      applyStimulus(1'b1, 32'h00000013, 32'h600, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
      tick();
      exp_cnt++;
      checkOutput("flush+fire cnt", decoded_cnt, 32'(exp_cnt));
      checkOutput("flush+fire valid", 32'(out_valid), 32'd0);

      // reset beats everything with skid full
      applyStimulus(1'b1, 32'h00000013, 32'h700, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 32'h00000033, 32'h704, 1'b0, 1'b0);
      tick();
      checkOutput("prereset in_ready", 32'(in_ready), 32'd0);
      rst = 1'b1;
      applyStimulus(1'b1, 32'h0000006F, 32'h708, 1'b1, 1'b1);
      tick();
      rst = 1'b0;
      exp_cnt = 0;
      checkOutput("rst out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst in_ready", 32'(in_ready), 32'd1);
      checkOutput("rst cnt", decoded_cnt, 32'(exp_cnt));
      checkOutput("rst out_ir", out_ir, 32'd0);
      checkOutput("rst out_pc", out_pc, 32'd0);

      // 17 handshakes: 4-bit counter wraps to 1
      for (int i = 0; i < 17; i++) begin
         applyStimulus(1'b1, 32'h00000013, 32'h800 + 32'(i * 4), 1'b1, 1'b0);
         tick();
      end
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      tick();
      exp_cnt += 17;
      checkOutput("cnt32 after 17", decoded_cnt, 32'(exp_cnt));
      checkOutput("cnt4 wrap", 32'(decoded_cnt_4), 32'(exp_cnt % 16));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
